// File: rtl/registros_param.sv
// Parametrised MIPS register file with a post-reset clear sweep and a registered debug read port.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding on o_RS/o_RT.
module registros_param #(
  parameter int NBITS    = 32,
  parameter int REGS     = 5,
  parameter int CELDAS   = 32,
  parameter int ZERO_REG = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_RegWrite,
  input  logic [REGS-1:0]  i_RS,
  input  logic [REGS-1:0]  i_RT,
  input  logic [REGS-1:0]  i_RD,
  input  logic [NBITS-1:0] i_DatoEscritura,
  input  logic [REGS-1:0]  i_debug_addr,
  output logic [NBITS-1:0] o_RS,
  output logic [NBITS-1:0] o_RT,
  output logic [NBITS-1:0] o_debug_dato,
  output logic             o_busy
);

  typedef enum logic {CLEAR, READY} state_e;

  localparam logic [REGS-1:0] LAST_PTR = REGS'(CELDAS - 1);
  localparam logic [REGS:0]   CEL_W    = (REGS + 1)'(CELDAS);

  state_e           state_q, state_d;
  logic [REGS-1:0]  ptr_q, ptr_d;
  logic [NBITS-1:0] dbg_q, dbg_d;
  logic [NBITS-1:0] mem_q [CELDAS];
  logic             clr;
  logic             wr_req;

  // An address is live only if implemented and not the hardwired zero register.
  function automatic logic addr_ok(input logic [REGS-1:0] a);
    return ({1'b0, a} < CEL_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [NBITS-1:0] rd_entry(input logic [REGS-1:0] a);
    if (addr_ok(a)) return mem_q[a];
    return '0;
  endfunction

  assign clr    = (state_q == CLEAR);
  assign o_busy = clr;
  assign wr_req = (state_q == READY) && i_RegWrite && addr_ok(i_RD);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dbg_d   = dbg_q;
    if (state_q == CLEAR) begin
      dbg_d = '0;
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST_PTR) begin
        state_d = READY;
        ptr_d   = '0;
      end
    end else begin
      // Debug sees the array as it was before this edge's write.
      dbg_d = rd_entry(i_debug_addr);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dbg_q   <= dbg_d;
    end
  end

  // Array has no reset of its own; the sweep zeroes it one entry per edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (clr) begin
        mem_q[ptr_q] <= '0;
      end else if (wr_req) begin
        mem_q[i_RD] <= i_DatoEscritura;
      end
    end
  end

  always_comb begin
    o_RS = clr ? '0 : rd_entry(i_RS);
    o_RT = clr ? '0 : rd_entry(i_RT);
`ifdef REGFILE_BYPASS_EN
    if (wr_req && (i_RS == i_RD)) o_RS = i_DatoEscritura;
    if (wr_req && (i_RT == i_RD)) o_RT = i_DatoEscritura;
`else
`endif
  end

  assign o_debug_dato = dbg_q;

endmodule

// File: tb/tb_registros_param.sv
// Bench for registros_param: two configurations (32 regs/zero reg, 16 regs/no zero reg) on shared stimulus.
module tb_registros_param;

  logic        i_clk = 1'b0;
  logic        i_reset, i_RegWrite;
  logic [4:0]  i_RS, i_RT, i_RD, i_debug_addr;
  logic [31:0] i_DatoEscritura;
  logic [31:0] rs0, rt0, dbg0, rs1, rt1, dbg1;
  logic        busy0, busy1;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  registros_param #(.NBITS(32), .REGS(5), .CELDAS(32), .ZERO_REG(1)) u0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_RegWrite(i_RegWrite), .i_RS(i_RS), .i_RT(i_RT),
    .i_RD(i_RD), .i_DatoEscritura(i_DatoEscritura), .i_debug_addr(i_debug_addr),
    .o_RS(rs0), .o_RT(rt0), .o_debug_dato(dbg0), .o_busy(busy0));

  registros_param #(.NBITS(32), .REGS(5), .CELDAS(16), .ZERO_REG(0)) u1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_RegWrite(i_RegWrite), .i_RS(i_RS), .i_RT(i_RT),
    .i_RD(i_RD), .i_DatoEscritura(i_DatoEscritura), .i_debug_addr(i_debug_addr),
    .o_RS(rs1), .o_RT(rt1), .o_debug_dato(dbg1), .o_busy(busy1));

  // Reference model: remaining clear edges per instance, plain array contents.
  int          cnt [2] = '{32, 16};
  logic [31:0] mem [2][32];
  logic [31:0] mdbg [2];
  bit          started = 1'b0;

  function automatic int cel(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic bit ok(int k, int a);
    return (a < cel(k)) && !((k == 0) && (a == 0));
  endfunction

  function automatic logic [31:0] exp_rd(int k, int a);
    if (cnt[k] > 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (i_RegWrite && ok(k, int'(i_RD)) && (a == int'(i_RD))) return i_DatoEscritura;
`endif
    if (ok(k, a)) return mem[k][a];
    return 32'h0;
  endfunction

  always @(posedge i_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (i_reset) begin
        cnt[k]  = cel(k);
        mdbg[k] = 32'h0;
        started = 1'b1;
      end else if (cnt[k] > 0) begin
        cnt[k]--;
        mdbg[k] = 32'h0;
        if (cnt[k] == 0)
          for (int a = 0; a < 32; a++) mem[k][a] = 32'h0;
      end else begin
        mdbg[k] = ok(k, int'(i_debug_addr)) ? mem[k][i_debug_addr] : 32'h0;
        if (i_RegWrite && ok(k, int'(i_RD))) mem[k][i_RD] = i_DatoEscritura;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (started) begin
      chk("busy0", {31'h0, busy0}, {31'h0, cnt[0] > 0});
      chk("busy1", {31'h0, busy1}, {31'h0, cnt[1] > 0});
      chk("rs0", rs0, exp_rd(0, int'(i_RS)));
      chk("rt0", rt0, exp_rd(0, int'(i_RT)));
      chk("rs1", rs1, exp_rd(1, int'(i_RS)));
      chk("rt1", rt1, exp_rd(1, int'(i_RT)));
      chk("dbg0", dbg0, mdbg[0]);
      chk("dbg1", dbg1, mdbg[1]);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    i_RegWrite = 1'b1; i_RD = rd; i_DatoEscritura = d;
    tick();
    i_RegWrite = 1'b0;
  endtask

  // Counts edges after reset release until busy drops; n1 records where u1 finishes.
  task automatic sweep(output int n0, output int n1, input bit poke);
    n0 = 0; n1 = 0;
    i_reset = 1'b0;
    if (poke) begin
      i_RegWrite = 1'b1; i_RD = 5'd3; i_DatoEscritura = 32'hAA;
    end
    while (busy0 && n0 < 100) begin
      tick();
      n0++;
      if (n0 == 5) i_RegWrite = 1'b0;
      if (!busy1 && n1 == 0) n1 = n0;
    end
  endtask

  initial begin
    int n0, n1;
    i_reset = 1'b1; i_RegWrite = 1'b0; i_RS = '0; i_RT = '0; i_RD = '0;
    i_debug_addr = '0; i_DatoEscritura = '0;
    tick(); tick();
    chk("reset_busy", {31'h0, busy0}, 32'h1);
    chk("reset_dbg", dbg0, 32'h0);

    sweep(n0, n1, 1'b1);
    chk("clear_edges32", n0, 32);
    chk("clear_edges16", n1, 16);
    for (int a = 0; a < 32; a++) begin
      i_RS = 5'(a); i_RT = 5'(31 - a);
      tick();
      chk("cleared_rs", rs0, 32'h0);
    end
    i_RT = 5'd3; #1;
    chk("r3_after_sweep", rt0, 32'h0);

    i_RS = 5'd5; i_RT = 5'd5; i_debug_addr = 5'd5;
    wr(5'd5, 32'hDEADBEEF);
    chk("r5_rs", rs0, 32'hDEADBEEF);
    chk("r5_rt", rt0, 32'hDEADBEEF);
    tick();
    chk("r5_dbg", dbg0, 32'hDEADBEEF);

    i_RS = 5'd0;
    wr(5'd0, 32'h12345678);
    chk("zero_reg_on", rs0, 32'h0);
    chk("zero_reg_off", rs1, 32'h12345678);

    wr(5'd4, 32'h44);
    wr(5'd20, 32'h55);
    i_RS = 5'd20; i_RT = 5'd4; #1;
    chk("oor_r20", rs1, 32'h0);
    chk("oor_r4", rt1, 32'h44);
    chk("inrange_r20", rs0, 32'h55);

    i_RS = 5'd7; i_RegWrite = 1'b1; i_RD = 5'd7; i_DatoEscritura = 32'h0F0F; #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_rs", rs0, 32'h0F0F);
`else
    chk("no_bypass_rs", rs0, 32'h0);
`endif
    tick();
    i_RegWrite = 1'b0;

    i_reset = 1'b1; tick();
    i_reset = 1'b0;
    repeat (10) tick();
    i_reset = 1'b1; tick();
    chk("midclear_busy", {31'h0, busy0}, 32'h1);
    sweep(n0, n1, 1'b0);
    chk("restart_edges32", n0, 32);
    i_RS = 5'd5; #1;
    chk("restart_r5", rs0, 32'h0);

    for (int c = 0; c < 2000; c++) begin
      i_reset         = ($urandom_range(199, 0) == 0);
      i_RegWrite      = $urandom_range(1, 0) == 1;
      i_RS            = 5'($urandom_range(31, 0));
      i_RT            = 5'($urandom_range(31, 0));
      i_RD            = ($urandom_range(3, 0) == 0) ? i_RS : 5'($urandom_range(31, 0));
      i_debug_addr    = 5'($urandom_range(31, 0));
      i_DatoEscritura = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
